// File: rtl/ecc_hamming_encoder.sv
// ---------------------------------------------------------------------------
// ecc_hamming_encoder
//
// SECDED Hamming encoder for the shared-memory write path. Each accepted data
// word gets PARITY_LENGTH Hamming check bits plus one overall parity bit. The
// fields are laid out the way ecc_hamming_decoder expects them. The datapath
// is a 2-stage valid/ready pipeline with one global stall. Test faults can be
// injected into a word as it is encoded. A wrapping counter tracks delivered
// words.
//
// Codeword positions run 1..DATA_WIDTH+PARITY_LENGTH. Check bits sit at the
// powers of two. Data bits fill the remaining positions in ascending order.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   input word valid
//   in_ready     out  encoder accepts input this cycle (combinational)
//   d_in         in   data word to encode
//   inject_mode  in   00 none, 01 single flip, 10 double flip, 11 none
//   inject_pos   in   flat codeword index to corrupt
//                     (0..DATA_WIDTH-1 data, then parity, then overall bit)
//   out_valid    out  encoded word valid
//   out_ready    in   downstream accepts output
//   d_out        out  data field (after injection)
//   parity_out   out  Hamming check bits (after injection)
//   odd_even_out out  overall parity bit (after injection)
//   enc_count    out  number of delivered words, wrapping
// ---------------------------------------------------------------------------
module ecc_hamming_encoder #(
  parameter int DATA_WIDTH    = 32,
  parameter int PARITY_LENGTH = 6,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    d_in,
  input  logic [1:0]               inject_mode,
  input  logic [5:0]               inject_pos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    d_out,
  output logic [PARITY_LENGTH-1:0] parity_out,
  output logic                     odd_even_out,
  output logic [CNT_WIDTH-1:0]     enc_count
);

  // Flat codeword: {overall, parity, data}
  localparam int CW_LEN = DATA_WIDTH + PARITY_LENGTH + 1;
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Even-parity Hamming check bits. Each data bit is folded into every check
  // bit that is selected by a set bit of its codeword position.
  function automatic logic [PARITY_LENGTH-1:0] hamming_parity(
    input logic [DATA_WIDTH-1:0] data
  );
    logic [PARITY_LENGTH-1:0] par;
    int k;
    par = '0;
    k   = 0;
    for (int pos = 1; pos < CW_LEN; pos++) begin
      if ((pos & (pos - 1)) != 32'sd0) begin
        if (data[k[IDX_W-1:0]]) begin
          par = par ^ pos[PARITY_LENGTH-1:0];
        end else begin
          par = par;
        end
        k = k + 1;
      end else begin
        k = k;
      end
    end
    return par;
  endfunction

  // Stage 1 registers
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [1:0]            s1_mode_q;
  logic [5:0]            s1_pos_q;

  // Stage 2 (output) registers
  logic                     out_valid_q;
  logic [DATA_WIDTH-1:0]    d_out_q;
  logic [PARITY_LENGTH-1:0] parity_q;
  logic                     odd_even_q;
  logic [CNT_WIDTH-1:0]     enc_count_q;

  // Combinational datapath
  logic                     adv_s;
  logic [PARITY_LENGTH-1:0] clean_par_s;
  logic [CW_LEN-1:0]        clean_cw_s;
  logic [6:0]               pos_a_s;
  logic [6:0]               pos_b_s;
  logic                     in_range_s;
  logic                     flip_one_s;
  logic                     flip_two_s;
  logic [CW_LEN-1:0]        flip_mask_s;
  logic [CW_LEN-1:0]        cw_d;

  // A single stall signal moves both stages together. Words only move when
  // the output slot is empty or is being drained this cycle.
  always_comb begin
    adv_s    = (!out_valid_q) | out_ready;
    in_ready = adv_s;
  end

  // Clean encoding of the stage-1 word.
  always_comb begin
    clean_par_s = hamming_parity(s1_data_q);
    clean_cw_s  = {^{s1_data_q, clean_par_s}, clean_par_s, s1_data_q};
  end

  // Fault injection mask. The second flip of a double injection wraps from
  // the overall bit back to data bit 0. An index past the end of the codeword
  // disables injection.
  always_comb begin
    pos_a_s    = {1'b0, s1_pos_q};
    in_range_s = (pos_a_s < 7'(CW_LEN));
    if (pos_a_s == 7'(CW_LEN - 1)) begin
      pos_b_s = 7'd0;
    end else begin
      pos_b_s = pos_a_s + 7'd1;
    end
    case (s1_mode_q)
      2'b01: begin
        flip_one_s = 1'b1;
        flip_two_s = 1'b0;
      end
      2'b10: begin
        flip_one_s = 1'b1;
        flip_two_s = 1'b1;
      end
      default: begin
        flip_one_s = 1'b0;
        flip_two_s = 1'b0;
      end
    endcase
    flip_mask_s = '0;
    for (int i = 0; i < CW_LEN; i++) begin
      flip_mask_s[i] = in_range_s &
                       ((flip_one_s & (7'(i) == pos_a_s)) |
                        (flip_two_s & (7'(i) == pos_b_s)));
    end
    cw_d = clean_cw_s ^ flip_mask_s;
  end

  // Stage 1: capture the input word and its injection request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 2'b00;
      s1_pos_q   <= 6'd0;
    end else if (adv_s) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= d_in;
        s1_mode_q <= inject_mode;
        s1_pos_q  <= inject_pos;
      end else begin
        s1_data_q <= s1_data_q;
        s1_mode_q <= s1_mode_q;
        s1_pos_q  <= s1_pos_q;
      end
    end else begin
      s1_valid_q <= s1_valid_q;
    end
  end

  // Stage 2: register the final (possibly corrupted) codeword fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      parity_q    <= '0;
      odd_even_q  <= 1'b0;
    end else if (adv_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        {odd_even_q, parity_q, d_out_q} <= cw_d;
      end else begin
        {odd_even_q, parity_q, d_out_q} <= {odd_even_q, parity_q, d_out_q};
      end
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Delivered-word counter. It wraps naturally at its full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      enc_count_q <= enc_count_q + CNT_WIDTH'(1);
    end else begin
      enc_count_q <= enc_count_q;
    end
  end

  assign out_valid    = out_valid_q;
  assign d_out        = d_out_q;
  assign parity_out   = parity_q;
  assign odd_even_out = odd_even_q;
  assign enc_count    = enc_count_q;

endmodule

// File: tb/tb_ecc_hamming_encoder.sv
// ---------------------------------------------------------------------------
// Testbench for ecc_hamming_encoder. The counter is narrowed to 10 bits so
// that its wrap point can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_ecc_hamming_encoder;

  localparam int DW = 32;
  localparam int PL = 6;
  localparam int CW = 10;
  localparam int N  = DW + PL + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d_in;
  logic [1:0]    inject_mode;
  logic [5:0]    inject_pos;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] d_out;
  logic [PL-1:0] parity_out;
  logic          odd_even_out;
  logic [CW-1:0] enc_count;

  always #5 clk = ~clk;

  ecc_hamming_encoder #(.DATA_WIDTH(DW), .PARITY_LENGTH(PL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .inject_mode(inject_mode), .inject_pos(inject_pos),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .parity_out(parity_out), .odd_even_out(odd_even_out), .enc_count(enc_count)
  );

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [N-1:0]  exp_q[$];
  int unsigned   exp_cnt = 0;
  bit            last_in_xfer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: choose the check bits so that the XOR of the positions of all
  // set codeword bits is zero (the syndrome of a clean word). Then make the
  // whole word even and apply the requested flips to the flat vector.
  function automatic logic [N-1:0] ref_word(input logic [DW-1:0] d, input logic [1:0] m,
                                            input logic [5:0] pos);
    int syn;
    int bitno;
    logic [PL-1:0] par;
    logic [N-1:0]  cw;
    logic [N-1:0]  one;
    syn   = 0;
    bitno = 0;
    for (int p = 1; p < N; p++) begin
      if ($countones(p) != 1) begin
        if (d[bitno]) syn = syn ^ p;
        bitno++;
      end
    end
    par = syn[PL-1:0];
    cw  = {^{d, par}, par, d};
    one = 1;
    if (int'(pos) < N) begin
      if (m == 2'b01) cw = cw ^ (one << pos);
      else if (m == 2'b10) cw = cw ^ (one << pos) ^ (one << ((int'(pos) + 1) % N));
    end
    return cw;
  endfunction

  // One clock: observe transfers at the falling edge, then return just after
  // the rising edge so that the caller can change inputs.
  task automatic step();
    logic [N-1:0] w;
    @(negedge clk);
    last_in_xfer = in_valid && in_ready;
    chk("enc_count", 64'(enc_count), 64'(exp_cnt));
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_output: observed word %0h expected none", {odd_even_out, parity_out, d_out});
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("out_word", 64'({odd_even_out, parity_out, d_out}), 64'(w));
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
    end
    if (last_in_xfer) exp_q.push_back(ref_word(d_in, inject_mode, inject_pos));
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] d; logic [1:0] m; logic [5:0] pos;
    logic [31:0] ed; logic [5:0] ep; logic eo;
  } dir_t;

  dir_t dirs[9];
  logic [DW-1:0] words[4];
  int idx;
  int guard;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dirs[0] = '{32'h0000_0000, 2'b00, 6'd0,  32'h0000_0000, 6'b000000, 1'b0};
    dirs[1] = '{32'h0000_0001, 2'b00, 6'd0,  32'h0000_0001, 6'b000011, 1'b1};
    dirs[2] = '{32'h0000_0002, 2'b00, 6'd0,  32'h0000_0002, 6'b000101, 1'b1};
    dirs[3] = '{32'h8000_0000, 2'b00, 6'd0,  32'h8000_0000, 6'b100110, 1'b0};
    dirs[4] = '{32'h0000_0001, 2'b01, 6'd0,  32'h0000_0000, 6'b000011, 1'b1};
    dirs[5] = '{32'h0000_0001, 2'b10, 6'd38, 32'h0000_0000, 6'b000011, 1'b0};
    dirs[6] = '{32'h0000_0001, 2'b01, 6'd50, 32'h0000_0001, 6'b000011, 1'b1};
    dirs[7] = '{32'h0000_0001, 2'b11, 6'd5,  32'h0000_0001, 6'b000011, 1'b1};
    dirs[8] = '{32'h0000_0002, 2'b01, 6'd32, 32'h0000_0002, 6'b000100, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    d_in = '0; inject_mode = 2'b00; inject_pos = 6'd0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d_out", 64'(d_out), 64'd0);
    chk("rst_parity", 64'(parity_out), 64'd0);
    chk("rst_odd_even", 64'(odd_even_out), 64'd0);
    chk("rst_enc_count", 64'(enc_count), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed words with known encodings and a latency check on each.
    for (int i = 0; i < 9; i++) begin
      d_in = dirs[i].d; inject_mode = dirs[i].m; inject_pos = dirs[i].pos;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("latency_1cyc_valid", 64'(out_valid), 64'd0);
      step();
      chk("latency_2cyc_valid", 64'(out_valid), 64'd1);
      chk("dir_d_out", 64'(d_out), 64'(dirs[i].ed));
      chk("dir_parity", 64'(parity_out), 64'(dirs[i].ep));
      chk("dir_odd_even", 64'(odd_even_out), 64'(dirs[i].eo));
    end
    step();

    // Stall: four words, output blocked for three cycles.
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    inject_mode = 2'b00; inject_pos = 6'd0;
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    for (int i = 0; i < 2; i++) begin
      d_in = words[idx]; step();
      if (last_in_xfer) idx++;
    end
    d_in = words[idx];
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_accept", 64'(last_in_xfer), 64'd0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      if (exp_q.size() != 0)
        chk("stall_stable", 64'({odd_even_out, parity_out, d_out}), 64'(exp_q[0]));
    end
    out_ready = 1'b1;
    guard = 0;
    while (idx < 4 && guard < 20) begin
      d_in = words[idx]; step();
      if (last_in_xfer) idx++;
      guard++;
    end
    chk("stall_all_accepted", 64'(idx), 64'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      d_in        = $urandom;
      inject_mode = 2'($urandom_range(0, 3));
      inject_pos  = 6'($urandom_range(0, 63));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a stream discards in-flight words.
    in_valid = 1'b1; inject_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      d_in = $urandom; step();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_d_out", 64'(d_out), 64'd0);
    chk("midrst_parity", 64'(parity_out), 64'd0);
    chk("midrst_odd_even", 64'(odd_even_out), 64'd0);
    chk("midrst_enc_count", 64'(enc_count), 64'd0);
    exp_q.delete(); exp_cnt = 0; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();
    chk("midrst_no_output", 64'(out_valid), 64'd0);

    // Counter wrap: stream until the count is all ones, then one more transfer.
    in_valid = 1'b1; out_ready = 1'b1; guard = 0;
    while (exp_cnt != (1 << CW) - 1 && guard < 3000) begin
      d_in = $urandom; inject_mode = 2'($urandom_range(0, 3)); inject_pos = 6'($urandom_range(0, 63));
      step();
      guard++;
    end
    chk("wrap_reached_max", 64'(enc_count), 64'((1 << CW) - 1));
    in_valid = 1'b0;
    step();
    chk("wrap_to_zero", 64'(enc_count), 64'd0);
    for (int i = 0; i < 3; i++) step();
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
